// File: rtl/gat_bram_load_bridge_if.sv
// Bus bundle for gat_bram_load_bridge: host load writes, per-channel BRAM writes,
// core start/ready handshake and feature-BRAM readback.
interface gat_bram_load_bridge_if #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 18,
    parameter int OUT_W     = 24,
    parameter int RD_ADDR_W = 16,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                        start;
    logic [NUM_CH*ADDR_W-1:0]    cfg_count;
    logic                        host_wr_en;
    logic [CH_W-1:0]             host_wr_ch;
    logic [ADDR_W+1:0]           host_wr_addr;
    logic [TOP_WIDTH-1:0]        host_wr_data;
    logic                        host_wr_ready;
    logic [NUM_CH-1:0]           bram_en;
    logic [NUM_CH-1:0]           bram_we;
    logic [NUM_CH*ADDR_W-1:0]    bram_addr;
    logic [NUM_CH*OUT_W-1:0]     bram_din;
    logic [NUM_CH-1:0]           load_done;
    logic                        core_start;
    logic                        core_ready;
    logic                        done;
    logic                        err_unaligned;
    logic                        err_range;
    logic                        rd_req;
    logic [RD_ADDR_W+1:0]        rd_addr;
    logic                        rd_valid;
    logic [TOP_WIDTH-1:0]        rd_data;
    logic [RD_ADDR_W-1:0]        feat_bram_addrb;
    logic [TOP_WIDTH-1:0]        feat_bram_dout;

    modport master (
        output start, cfg_count, host_wr_en, host_wr_ch, host_wr_addr, host_wr_data,
               core_ready, rd_req, rd_addr, feat_bram_dout,
        input  host_wr_ready, bram_en, bram_we, bram_addr, bram_din, load_done,
               core_start, done, err_unaligned, err_range, rd_valid, rd_data, feat_bram_addrb
    );

    modport slave (
        input  start, cfg_count, host_wr_en, host_wr_ch, host_wr_addr, host_wr_data,
               core_ready, rd_req, rd_addr, feat_bram_dout,
        output host_wr_ready, bram_en, bram_we, bram_addr, bram_din, load_done,
               core_start, done, err_unaligned, err_range, rd_valid, rd_data, feat_bram_addrb
    );
endinterface

// File: rtl/gat_bram_load_bridge.sv
// Host-to-accelerator load bridge: narrows byte-addressed host writes onto NUM_CH BRAM
// channels, tracks per-channel completion, kicks the core and serves feature readback.
module gat_bram_load_bridge #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 18,
    parameter int OUT_W     = 24,
    parameter int RD_ADDR_W = 16,
    parameter int RD_LAT    = 1,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                   clk,
    input logic                   rst,
    gat_bram_load_bridge_if.slave bus
);
    localparam int STAGES = RD_LAT;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_RUN, S_DONE} state_t;

    state_t                          state;
    logic                            wr_ready_q;
    logic                            core_start_q;
    logic                            done_q;
    logic                            err_unaligned_q;
    logic                            err_range_q;
    logic                            rdy_q;

    logic [NUM_CH-1:0][ADDR_W-1:0]   cfg_in;
    logic [NUM_CH-1:0][ADDR_W-1:0]   cfg_q;
    logic [NUM_CH-1:0][ADDR_W-1:0]   cnt_q;
    logic [NUM_CH-1:0]               load_done_q;
    logic [NUM_CH-1:0]               bram_en_q;
    logic [NUM_CH-1:0][ADDR_W-1:0]   bram_addr_q;
    logic [NUM_CH-1:0][OUT_W-1:0]    bram_din_q;

    logic [STAGES:0]                 vld_pipe;
    logic                            rd_valid_q;
    logic [TOP_WIDTH-1:0]            rd_data_q;
    logic [RD_ADDR_W-1:0]            addrb_q;

    logic                            open;
    logic                            wr_fire;
    logic                            unaligned;
    logic [ADDR_W-1:0]               waddr;
    logic [NUM_CH-1:0]               ch_ok;
    logic [NUM_CH-1:0]               acc;

    assign cfg_in    = bus.cfg_count;
    assign open      = bus.start && (state == S_IDLE || state == S_DONE);
    assign wr_fire   = bus.host_wr_en && wr_ready_q;
    assign unaligned = |bus.host_wr_addr[1:0];
    assign waddr     = bus.host_wr_addr[ADDR_W+1:2];

    // A channel index outside NUM_CH matches no lane, so it lands in the range error.
    always_comb begin
        ch_ok = '0;
        for (int c = 0; c < NUM_CH; c++)
            ch_ok[c] = (bus.host_wr_ch == CH_W'(c)) && (waddr < cfg_q[c]) && !load_done_q[c];
        acc = (wr_fire && !unaligned) ? ch_ok : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wr_ready_q      <= 1'b0;
            core_start_q    <= 1'b0;
            done_q          <= 1'b0;
            err_unaligned_q <= 1'b0;
            err_range_q     <= 1'b0;
            rdy_q           <= 1'b0;
        end else begin
            rdy_q        <= bus.core_ready;
            core_start_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state           <= S_LOAD;
                        wr_ready_q      <= 1'b1;
                        done_q          <= 1'b0;
                        err_unaligned_q <= 1'b0;
                        err_range_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (wr_fire && unaligned) err_unaligned_q <= 1'b1;
                    if (wr_fire && !(|ch_ok)) err_range_q     <= 1'b1;
                    if (&load_done_q) begin
                        state        <= S_KICK;
                        wr_ready_q   <= 1'b0;
                        core_start_q <= 1'b1;
                    end
                end
                S_KICK: state <= S_RUN;
                // Only a fresh rise completes RUN; a level held high since before RUN does not.
                S_RUN: begin
                    if (bus.core_ready && !rdy_q) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q       <= '0;
            cnt_q       <= '0;
            load_done_q <= '0;
            bram_en_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                bram_en_q[c]   <= acc[c];
                bram_addr_q[c] <= acc[c] ? waddr : '0;
                bram_din_q[c]  <= acc[c] ? bus.host_wr_data[OUT_W-1:0] : '0;
                if (open) begin
                    cfg_q[c]       <= cfg_in[c];
                    cnt_q[c]       <= '0;
                    load_done_q[c] <= (cfg_in[c] == '0);
                end else if (acc[c]) begin
                    cnt_q[c] <= cnt_q[c] + ADDR_W'(1);
                    if (cnt_q[c] + ADDR_W'(1) == cfg_q[c]) load_done_q[c] <= 1'b1;
                end
            end
        end
    end

    // Readback: address register, RD_LAT BRAM cycles, then an output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            addrb_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], bus.rd_req};
            rd_valid_q <= vld_pipe[STAGES];
            if (bus.rd_req)         addrb_q   <= bus.rd_addr[RD_ADDR_W+1:2];
            if (vld_pipe[STAGES])   rd_data_q <= bus.feat_bram_dout;
        end
    end

    if (OUT_W < TOP_WIDTH) begin : g_unused_data
        logic unused_hi;
        assign unused_hi = &{1'b0, bus.host_wr_data[TOP_WIDTH-1:OUT_W]};
    end

    logic unused_rd_lo;
    assign unused_rd_lo = &{1'b0, bus.rd_addr[1:0]};

    assign bus.host_wr_ready   = wr_ready_q;
    assign bus.bram_en         = bram_en_q;
    assign bus.bram_we         = bram_en_q;
    assign bus.bram_addr       = bram_addr_q;
    assign bus.bram_din        = bram_din_q;
    assign bus.load_done       = load_done_q;
    assign bus.core_start      = core_start_q;
    assign bus.done            = done_q;
    assign bus.err_unaligned   = err_unaligned_q;
    assign bus.err_range       = err_range_q;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.feat_bram_addrb = addrb_q;
endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Scoreboard bench for gat_bram_load_bridge: queued expected BRAM writes and readback
// words are compared as the bridge produces them, plus directed state/flag checks.
module tb_gat_bram_load_bridge;
    localparam int TOP_WIDTH = 32;
    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 18;
    localparam int OUT_W     = 24;
    localparam int RD_ADDR_W = 16;
    localparam int RD_LAT    = 2;
    localparam int CH_W      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gat_bram_load_bridge_if #(
        .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W),
        .OUT_W(OUT_W), .RD_ADDR_W(RD_ADDR_W), .CH_W(CH_W)
    ) bus ();

    gat_bram_load_bridge #(
        .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .OUT_W(OUT_W),
        .RD_ADDR_W(RD_ADDR_W), .RD_LAT(RD_LAT), .CH_W(CH_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Feature BRAM model with RD_LAT cycles of read latency.
    function automatic logic [31:0] feat_word(input logic [15:0] a);
        return 32'h5A00_0000 ^ {a, ~a};
    endfunction

    logic [31:0] fpipe [RD_LAT];
    always @(posedge clk) begin
        fpipe[0] <= feat_word(bus.feat_bram_addrb);
        for (int i = 1; i < RD_LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign bus.feat_bram_dout = fpipe[RD_LAT-1];

    typedef struct packed {
        int unsigned       cyc;
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  din;
    } wr_exp_t;

    typedef struct packed {
        int unsigned       cyc;
        logic [31:0]       data;
    } rd_exp_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];

    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        if (bus.bram_en != '0) begin
            if (wq.size() == 0) chk("bram_unexpected", bus.bram_en, 0);
            else begin
                we = wq.pop_front();
                chk("bram_cyc", cyc, we.cyc);
                chk("bram_en", bus.bram_en, 4'b1 << we.ch);
                chk("bram_we", bus.bram_we, 4'b1 << we.ch);
                chk("bram_addr", bus.bram_addr[int'(we.ch)*ADDR_W +: ADDR_W], we.addr);
                chk("bram_din", bus.bram_din[int'(we.ch)*OUT_W +: OUT_W], we.din);
                for (int c = 0; c < NUM_CH; c++)
                    if (c != int'(we.ch))
                        chk("bram_other_ch", {bus.bram_addr[c*ADDR_W +: ADDR_W],
                                              bus.bram_din[c*OUT_W +: OUT_W]}, 0);
            end
        end else if (wq.size() != 0 && wq[0].cyc < cyc) begin
            chk("bram_missing", bus.bram_en, 4'b1 << wq[0].ch);
            void'(wq.pop_front());
        end

        if (bus.rd_valid) begin
            if (rq.size() == 0) chk("rd_unexpected", bus.rd_valid, 0);
            else begin
                re = rq.pop_front();
                chk("rd_cyc", cyc, re.cyc);
                chk("rd_data", bus.rd_data, re.data);
            end
        end else if (rq.size() != 0 && rq[0].cyc < cyc) begin
            chk("rd_missing", bus.rd_valid, 1);
            void'(rq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        bus.host_wr_en = 1'b0;
        bus.rd_req     = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [ADDR_W+1:0] addr, input logic [31:0] data,
                      input bit accept);
        tick();
        bus.host_wr_en   = 1'b1;
        bus.host_wr_ch   = CH_W'(ch);
        bus.host_wr_addr = addr;
        bus.host_wr_data = data;
        if (accept) wq.push_back('{cyc + 1, CH_W'(ch), addr[ADDR_W+1:2], data[OUT_W-1:0]});
    endtask

    function automatic logic [NUM_CH*ADDR_W-1:0] mk_cfg(input int c0, c1, c2, c3);
        return {ADDR_W'(c3), ADDR_W'(c2), ADDR_W'(c1), ADDR_W'(c0)};
    endfunction

    task automatic open_session(input logic [NUM_CH*ADDR_W-1:0] cfg);
        tick();
        bus.host_wr_en = 1'b0;
        bus.cfg_count  = cfg;
        bus.start      = 1'b1;
        @(negedge clk);
        chk("ready_before_open", bus.host_wr_ready, 0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("ready_after_open", bus.host_wr_ready, 1);
    endtask

    task automatic chk_idle_outs();
        chk("idle_bram_en", bus.bram_en, 0);
        chk("idle_bram_we", bus.bram_we, 0);
        chk("idle_bram_addr", |bus.bram_addr, 0);
        chk("idle_bram_din", |bus.bram_din, 0);
        chk("idle_load_done", bus.load_done, 0);
        chk("idle_core_start", bus.core_start, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_err", {bus.err_unaligned, bus.err_range}, 0);
        chk("idle_rd_valid", bus.rd_valid, 0);
        chk("idle_rd_data", bus.rd_data, 0);
        chk("idle_addrb", bus.feat_bram_addrb, 0);
        chk("idle_wr_ready", bus.host_wr_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [4];
        int idx;
        bus.start = 1'b0; bus.cfg_count = '0; bus.host_wr_en = 1'b0; bus.host_wr_ch = '0;
        bus.host_wr_addr = '0; bus.host_wr_data = '0; bus.core_ready = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outs();

        // Writes outside a session are ignored silently
        wr(0, 20'h6, 32'h1234_5678, 1'b0);
        idle();
        @(negedge clk);
        chk("nosession_err", {bus.err_unaligned, bus.err_range}, 0);

        // Readback: 8 back-to-back words, then one with low address bits set
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.rd_req  = 1'b1;
            bus.rd_addr = 18'(i * 4);
            rq.push_back('{cyc + 2 + RD_LAT, feat_word(16'(i))});
        end
        tick();
        bus.rd_addr = 18'h23;
        rq.push_back('{cyc + 2 + RD_LAT, feat_word(16'd8)});
        idle();
        repeat (6) idle();
        chk("rd_q_drained", rq.size(), 0);

        // Session A: basic load {3,2,4,1}
        cnt = '{3, 2, 4, 1};
        open_session(mk_cfg(3, 2, 4, 1));
        idx = 0;
        for (int c = 0; c < 3; c++)
            for (int w = 0; w < cnt[c]; w++) begin
                wr(c, 20'(w * 4), 32'hA5A5_0000 + 32'(idx), 1'b1);
                idx++;
            end
        wr(3, 20'h0, 32'hA5A5_0000 + 32'(idx), 1'b1);
        @(negedge clk);
        chk("a_ld_pre_last", bus.load_done, 4'b0111);
        idle();
        @(negedge clk);
        chk("a_ld_all", bus.load_done, 4'b1111);
        chk("a_kick_early", bus.core_start, 0);
        chk("a_ready_n1", bus.host_wr_ready, 1);
        idle();
        @(negedge clk);
        chk("a_core_start", bus.core_start, 1);
        chk("a_ready_fall", bus.host_wr_ready, 0);
        idle();
        @(negedge clk);
        chk("a_core_start_pulse", bus.core_start, 0);
        wr(0, 20'h6, 32'hFFFF_FFFF, 1'b0);
        idle();
        @(negedge clk);
        chk("a_run_wr_no_err", {bus.err_unaligned, bus.err_range}, 0);
        chk("a_done_before", bus.done, 0);
        tick();
        bus.core_ready = 1'b1;
        @(negedge clk);
        chk("a_done_same", bus.done, 0);
        tick();
        @(negedge clk);
        chk("a_done", bus.done, 1);
        tick();
        bus.core_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("a_done_sticky", bus.done, 1);

        // Session B: restart from DONE, error cases, start ignored in LOAD
        open_session(mk_cfg(4, 2, 2, 2));
        chk("b_done_clr", bus.done, 0);
        chk("b_ld_clr", bus.load_done, 0);
        wr(0, 20'h6, 32'h0BAD_0006, 1'b0);
        idle();
        @(negedge clk);
        chk("b_err_unaligned", bus.err_unaligned, 1);
        chk("b_err_range_clear", bus.err_range, 0);
        for (int w = 0; w < 4; w++) wr(0, 20'(w * 4), 32'h1100_0000 + 32'(w), 1'b1);
        idle();
        @(negedge clk);
        chk("b_ld_ch0", bus.load_done, 4'b0001);
        chk("b_err_range_still0", bus.err_range, 0);
        wr(0, 20'h0, 32'h0BAD_0005, 1'b0);
        idle();
        @(negedge clk);
        chk("b_err_range_done_ch", bus.err_range, 1);
        chk("b_ld_unchanged", bus.load_done, 4'b0001);
        tick();
        bus.cfg_count = mk_cfg(0, 0, 0, 0);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("b_start_ignored_ld", bus.load_done, 4'b0001);
        chk("b_start_ignored_err", {bus.err_unaligned, bus.err_range}, 2'b11);
        chk("b_start_ignored_rdy", bus.host_wr_ready, 1);
        for (int c = 1; c < 4; c++)
            for (int w = 0; w < 2; w++) wr(c, 20'(w * 4), 32'h2200_0000 + 32'(c * 16 + w), 1'b1);
        repeat (4) idle();
        tick();
        bus.core_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("b_done", bus.done, 1);

        // Session C: zero counts, core_ready already high through KICK/RUN
        open_session(mk_cfg(0, 0, 0, 1));
        chk("c_ld_zero", bus.load_done, 4'b0111);
        chk("c_err_clr", {bus.err_unaligned, bus.err_range}, 0);
        chk("c_done_clr", bus.done, 0);
        wr(3, 20'h15, 32'h0BAD_0015, 1'b0);
        idle();
        @(negedge clk);
        chk("c_both_err", {bus.err_unaligned, bus.err_range}, 2'b11);
        wr(3, 20'h0, 32'hDEAD_BEEF, 1'b1);
        idle();
        idle();
        @(negedge clk);
        chk("c_core_start", bus.core_start, 1);
        repeat (5) idle();
        @(negedge clk);
        chk("c_held_ready_no_done", bus.done, 0);
        tick();
        bus.core_ready = 1'b0;
        tick();
        bus.core_ready = 1'b1;
        @(negedge clk);
        chk("c_done_same", bus.done, 0);
        tick();
        @(negedge clk);
        chk("c_done", bus.done, 1);
        tick();
        bus.core_ready = 1'b0;

        // Reset mid-LOAD aborts the session
        open_session(mk_cfg(2, 2, 2, 2));
        wr(0, 20'h0, 32'h3300_0000, 1'b1);
        repeat (2 + $urandom_range(0, 3)) idle();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_idle_outs();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outs();
        open_session(mk_cfg(2, 2, 2, 2));
        wr(0, 20'h0, 32'h4400_0000, 1'b1);
        idle();
        @(negedge clk);
        chk("r_cnt_cleared", bus.load_done, 4'b0000);
        wr(0, 20'h4, 32'h4400_0001, 1'b1);
        idle();
        @(negedge clk);
        chk("r_ld_ch0", bus.load_done, 4'b0001);

        repeat (4) idle();
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/gat_bram_load_bridge.md
# gat_bram_load_bridge

Parametrised host-to-accelerator load bridge for the GAT core. It generalises the fixed four-port BRAM byte-address adaptation to `NUM_CH` load channels. Each channel converts 32-bit byte-addressed host writes into registered, narrowed BRAM writes and range-checks them against a runtime word count. The block counts writes per channel, raises per-channel `load_done` itself, sequences the core start/ready handshake, and provides a pipelined byte-addressed readback path for the output-feature BRAM.

## Interface
Parameters:
- `TOP_WIDTH`, 32: host data width.
- `NUM_CH`, 4: number of load channels (h_data, node_info, weight, subgraph).
- `ADDR_W`, 18: word-address width per channel. The host byte address is `ADDR_W+2` bits.
- `OUT_W`, 24: BRAM data width per channel. It is the low `OUT_W` bits of the host word.
- `RD_ADDR_W`, 16: feature BRAM word-address width.
- `RD_LAT`, 1: feature BRAM read latency in cycles (1–3).
- `CH_W`, $clog2(NUM_CH) (minimum 1): channel select width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled. Opens a load session.
- `cfg_count`  in  NUM_CH*ADDR_W  expected words per channel, channel c at `[c*ADDR_W +: ADDR_W]`. Sampled on session open.
- `host_wr_en`  in  1  host write strobe.
- `host_wr_ch`  in  CH_W  target channel.
- `host_wr_addr`  in  ADDR_W+2  byte address.
- `host_wr_data`  in  TOP_WIDTH  write data.
- `host_wr_ready`  out  1  high only in LOAD.
- `bram_en`, `bram_we`  out  NUM_CH  per-channel write strobes.
- `bram_addr`  out  NUM_CH*ADDR_W  word addresses.
- `bram_din`  out  NUM_CH*OUT_W  write data.
- `load_done`  out  NUM_CH  sticky per-channel completion.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_ready`  in  1  core completion level (`gat_ready`).
- `done`  out  1  session complete.
- `err_unaligned`, `err_range`  out  1  sticky error flags.
- `rd_req`  in  1  readback request.
- `rd_addr`  in  RD_ADDR_W+2  byte address.
- `rd_valid`  out  1  readback data valid.
- `rd_data`  out  TOP_WIDTH  readback data.
- `feat_bram_addrb`  out  RD_ADDR_W  feature BRAM address.
- `feat_bram_dout`  in  TOP_WIDTH  feature BRAM data.

## Operation
FSM states: IDLE, LOAD, KICK, RUN, DONE.

Transitions:
- IDLE/DONE → LOAD on `start`. This transition:
  - clears counters, `load_done`, both error flags and `done`;
  - latches `cfg_count`.
- `start` is ignored in LOAD, KICK and RUN.
- LOAD → KICK when all `load_done` bits are 1. Any channel with `cfg_count`=0 is done on entry.
- KICK → RUN after one cycle. `core_start` is 1 only in KICK.
- RUN → DONE on a rising edge of `core_ready`, detected against a registered copy. A level that is already high on RUN entry does not complete RUN.

Write acceptance, evaluated when `host_wr_en && host_wr_ready`:
- Word address is `host_wr_addr[ADDR_W+1:2]`.
- If `host_wr_addr[1:0]`≠0: the write is dropped and `err_unaligned` is set.
- If `host_wr_ch`≥`NUM_CH`, or word address ≥ latched count, or the channel's `load_done` is already 1: the write is dropped and `err_range` is set.
- If both the alignment and range conditions apply, both flags are set.
- Otherwise the write is accepted:
  - the target channel's `bram_en`, `bram_we`, `bram_addr` and `bram_din` (= data[OUT_W-1:0]) are registered;
  - that channel's counter increments;
  - when counter+1 equals the count, `load_done[c]` is set.
- Duplicate addresses count as new writes. Completion is word-count based, not coverage based.
- Writes presented outside LOAD are ignored with no error.

Readback:
- Fully pipelined, one request per cycle, legal in any state.
- Word address is `rd_addr[RD_ADDR_W+1:2]`. Low bits are ignored.

## Timing
- Reset values: state IDLE. Every output is 0, including `bram_*`, `core_start`, `done`, `load_done`, errors, `rd_valid`, `rd_data`, `feat_bram_addrb` and `host_wr_ready`.
- `rst` mid-session aborts immediately. Nothing is retained.
- `host_wr_ready` rises the cycle after `start` is sampled.
- Accepted write at cycle N:
  - `bram_*` for that channel is high for exactly cycle N+1, with all other channels 0;
  - the resulting `load_done` bit is high from N+1.
- Last write at N:
  - `load_done` complete at N+1;
  - state is KICK at N+2, so `core_start` is high during N+2;
  - `host_wr_ready` falls at N+2.
- Write rate is one word per cycle. There is no backpressure inside LOAD.
- `rd_req` at N:
  - `feat_bram_addrb` is valid at N+1;
  - `rd_valid`=1 and `rd_data` are valid at N+2+RD_LAT, for one cycle per request.
- `done` stays high from the RUN→DONE edge until the next session opens or reset.

## Test plan
- Reset: assert `rst` for 3 cycles at random points → every output is 0 and state is IDLE; repeat mid-LOAD → counters are cleared.
- Basic load: `cfg_count` = {3,2,4,1}, host writes every word of every channel in order (byte addrs 0,4,8,...; data 0xA5A5_0000+i) → `bram_din` = low 24 bits, per-channel 1-cycle strobes, `core_start` pulses 2 cycles after the final write, `done` follows the `core_ready` rise.
- Errors: write addr 0x6 → `err_unaligned`=1 and no strobe; write word 5 when count is 4 → `err_range`=1; a 5th write to a completed channel → `err_range`=1 with the count unchanged.
- Zero-count and back-to-back: `cfg_count`={0,0,0,1}, one write → KICK; `core_ready` held high from before KICK → stays in RUN until it toggles low then high.
- Readback: 8 consecutive `rd_req` at byte addrs 0x0..0x1C with `RD_LAT`=2 → `rd_valid` is high for 8 consecutive cycles starting 4 cycles after the first request, with data matching the BRAM model.
- Session restart: `start` in DONE → `load_done`, errors and `done` are cleared next cycle and the new `cfg_count` is honoured; `start` pulsed during LOAD → ignored.
